// File: rtl/iob_asym_buffered_converter.sv
`default_nettype none
// ============================================================================
// Module      : iob_asym_buffered_converter
// Description : Asymmetric-width adapter between a user write/read port pair
//               and a lane-split dual-port RAM (write packing / read cache).
// Revision    : 1.0
// ============================================================================
module iob_asym_buffered_converter #(
    parameter int W_DATA_W   = 32,
    parameter int R_DATA_W   = 8,
    parameter int ADDR_W     = 4,
    parameter int BIG_ENDIAN = 0,
    localparam int MAXDATA_W = (W_DATA_W > R_DATA_W) ? W_DATA_W : R_DATA_W,
    localparam int MINDATA_W = (W_DATA_W > R_DATA_W) ? R_DATA_W : W_DATA_W,
    localparam int R         = MAXDATA_W / MINDATA_W,
    localparam int L         = $clog2(R),
    localparam int MINADDR_W = ADDR_W - L,
    localparam int W_ADDR_W  = (W_DATA_W > R_DATA_W) ? MINADDR_W : ADDR_W,
    localparam int R_ADDR_W  = (R_DATA_W > W_DATA_W) ? MINADDR_W : ADDR_W
) (
    input  logic                 clk_i,
    input  logic                 cke_i,
    input  logic                 rst_i,
    input  logic                 w_en_i,
    input  logic [W_ADDR_W-1:0]  w_addr_i,
    input  logic [W_DATA_W-1:0]  w_data_i,
    input  logic                 flush_i,
    output logic                 busy_o,
    input  logic                 r_en_i,
    input  logic [R_ADDR_W-1:0]  r_addr_i,
    output logic [R_DATA_W-1:0]  r_data_o,
    output logic                 r_valid_o,
    output logic                 ext_mem_clk_o,
    output logic [R-1:0]         ext_mem_w_en_o,
    output logic [MINADDR_W-1:0] ext_mem_w_addr_o,
    output logic [MAXDATA_W-1:0] ext_mem_w_data_o,
    output logic [R-1:0]         ext_mem_r_en_o,
    output logic [MINADDR_W-1:0] ext_mem_r_addr_o,
    input  logic [MAXDATA_W-1:0] ext_mem_r_data_i
);

    assign ext_mem_clk_o = clk_i;

    if (W_DATA_W < R_DATA_W) begin : g_pack
        logic [MAXDATA_W-1:0] r_pbuf, r_mw_data, r_fwd_data;
        logic [R-1:0]         r_pmask, r_mw_en, r_fwd_sel;
        logic [MINADDR_W-1:0] r_paddr, r_mw_addr;
        logic                 r_flush_pend, r_rvalid;

        logic [MINADDR_W-1:0] w_word;
        logic [L-1:0]         w_lane;
        logic [R-1:0]         w_lmask, w_mmask;
        logic [MAXDATA_W-1:0] w_lbits, w_ldata, w_mbuf;
        logic                 w_evict, w_flush;
        logic [MAXDATA_W-1:0] w_pbuf_nx, w_mw_data_nx, w_fwd_data_nx;
        logic [R-1:0]         w_pmask_nx, w_mw_en_nx, w_fwd_sel_nx;
        logic [MINADDR_W-1:0] w_paddr_nx, w_mw_addr_nx;
        logic                 w_flush_pend_nx;

        always_comb begin
            w_word  = w_addr_i[ADDR_W-1:L];
            w_lane  = (BIG_ENDIAN != 0) ? ~w_addr_i[L-1:0] : w_addr_i[L-1:0];
            w_lmask = R'(1) << w_lane;
            w_lbits = MAXDATA_W'({MINDATA_W{1'b1}}) << (MINDATA_W * w_lane);
            w_ldata = MAXDATA_W'(w_data_i) << (MINDATA_W * w_lane);
            w_mmask = r_pmask | w_lmask;
            w_mbuf  = (r_pbuf & ~w_lbits) | w_ldata;
            w_flush = flush_i | r_flush_pend;
            w_evict = w_en_i && (r_pmask != '0) && (w_word != r_paddr);

            w_pbuf_nx       = r_pbuf;
            w_pmask_nx      = r_pmask;
            w_paddr_nx      = r_paddr;
            w_mw_en_nx      = '0;
            w_mw_addr_nx    = r_mw_addr;
            w_mw_data_nx    = r_mw_data;
            w_flush_pend_nx = 1'b0;

            if (w_en_i) begin
                if (w_evict) begin
                    w_mw_en_nx   = r_pmask;
                    w_mw_addr_nx = r_paddr;
                    w_mw_data_nx = r_pbuf;
                    w_pbuf_nx    = w_ldata;
                    w_pmask_nx   = w_lmask;
                    w_paddr_nx   = w_word;
                    // write port is taken by the eviction, so a coincident flush waits a cycle
                    w_flush_pend_nx = w_flush;
                end else if ((&w_mmask) || w_flush) begin
                    w_mw_en_nx   = w_mmask;
                    w_mw_addr_nx = w_word;
                    w_mw_data_nx = w_mbuf;
                    w_pbuf_nx    = w_mbuf;
                    w_pmask_nx   = '0;
                    w_paddr_nx   = w_word;
                end else begin
                    w_pbuf_nx  = w_mbuf;
                    w_pmask_nx = w_mmask;
                    w_paddr_nx = w_word;
                end
            end else if (w_flush && (r_pmask != '0)) begin
                w_mw_en_nx   = r_pmask;
                w_mw_addr_nx = r_paddr;
                w_mw_data_nx = r_pbuf;
                w_pmask_nx   = '0;
            end

            // RAM is read-first, so pending and in-flight lanes must be forwarded
            w_fwd_data_nx = r_mw_data;
            w_fwd_sel_nx  = '0;
            for (int i = 0; i < R; i++) begin
                if (r_pmask[i] && (r_paddr == r_addr_i)) begin
                    w_fwd_sel_nx[i] = 1'b1;
                    w_fwd_data_nx[i*MINDATA_W +: MINDATA_W] = r_pbuf[i*MINDATA_W +: MINDATA_W];
                end else if (r_mw_en[i] && (r_mw_addr == r_addr_i)) begin
                    w_fwd_sel_nx[i] = 1'b1;
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_pmask      <= '0;
                r_mw_en      <= '0;
                r_flush_pend <= 1'b0;
                r_rvalid     <= 1'b0;
            end else if (cke_i) begin
                r_pbuf       <= w_pbuf_nx;
                r_pmask      <= w_pmask_nx;
                r_paddr      <= w_paddr_nx;
                r_mw_en      <= w_mw_en_nx;
                r_mw_addr    <= w_mw_addr_nx;
                r_mw_data    <= w_mw_data_nx;
                r_flush_pend <= w_flush_pend_nx;
                r_rvalid     <= r_en_i;
                r_fwd_sel    <= w_fwd_sel_nx;
                r_fwd_data   <= w_fwd_data_nx;
            end
        end

        always_comb begin
            r_data_o = ext_mem_r_data_i;
            for (int i = 0; i < R; i++) begin
                if (r_fwd_sel[i]) begin
                    r_data_o[i*MINDATA_W +: MINDATA_W] = r_fwd_data[i*MINDATA_W +: MINDATA_W];
                end
            end
        end

        assign ext_mem_w_en_o   = r_mw_en;
        assign ext_mem_w_addr_o = r_mw_addr;
        assign ext_mem_w_data_o = r_mw_data;
        assign ext_mem_r_en_o   = {R{r_en_i & cke_i}};
        assign ext_mem_r_addr_o = r_addr_i;
        assign busy_o           = (|r_pmask) | (|r_mw_en);
        assign r_valid_o        = r_rvalid;

    end else if (W_DATA_W > R_DATA_W) begin : g_cache
        logic [MAXDATA_W-1:0] r_cdata, r_fill_fwd_data;
        logic [MINADDR_W-1:0] r_caddr, r_fill_word;
        logic                 r_cvalid, r_fill, r_fill_fwd, r_rvalid, r_hit;
        logic [MINDATA_W-1:0] r_hit_data;
        logic [L-1:0]         r_lane;

        logic [MAXDATA_W-1:0] w_fill_data, w_view_data;
        logic [MINADDR_W-1:0] w_view_addr, w_rword;
        logic                 w_view_valid, w_hit;
        logic [L-1:0]         w_rlane;
        logic                 w_unused;

        assign w_unused = flush_i;

        // a fill landing this cycle already counts as cache content for new reads
        always_comb begin
            w_rword     = r_addr_i[ADDR_W-1:L];
            w_rlane     = (BIG_ENDIAN != 0) ? ~r_addr_i[L-1:0] : r_addr_i[L-1:0];
            w_fill_data = r_fill_fwd ? r_fill_fwd_data : ext_mem_r_data_i;
            if (r_fill) begin
                w_view_data  = w_fill_data;
                w_view_addr  = r_fill_word;
                w_view_valid = 1'b1;
            end else begin
                w_view_data  = r_cdata;
                w_view_addr  = r_caddr;
                w_view_valid = r_cvalid;
            end
            w_hit = w_view_valid && (w_view_addr == w_rword);
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_cvalid <= 1'b0;
                r_fill   <= 1'b0;
                r_rvalid <= 1'b0;
            end else if (cke_i) begin
                r_rvalid <= r_en_i;
                r_fill   <= r_en_i && !w_hit;
                if (r_en_i) begin
                    r_hit           <= w_hit;
                    r_hit_data      <= w_view_data[w_rlane*MINDATA_W +: MINDATA_W];
                    r_lane          <= w_rlane;
                    r_fill_word     <= w_rword;
                    r_fill_fwd      <= w_en_i && (w_addr_i == w_rword);
                    r_fill_fwd_data <= w_data_i;
                end
                if (r_fill) begin
                    r_cvalid <= 1'b1;
                    r_caddr  <= r_fill_word;
                    r_cdata  <= (w_en_i && (w_addr_i == r_fill_word)) ? w_data_i : w_fill_data;
                end else if (w_en_i && r_cvalid && (w_addr_i == r_caddr)) begin
                    r_cdata <= w_data_i;
                end
            end
        end

        assign ext_mem_w_en_o   = {R{w_en_i & cke_i}};
        assign ext_mem_w_addr_o = w_addr_i;
        assign ext_mem_w_data_o = w_data_i;
        assign ext_mem_r_en_o   = {R{r_en_i & cke_i & ~w_hit}};
        assign ext_mem_r_addr_o = w_rword;
        assign r_data_o         = r_hit ? r_hit_data : ext_mem_r_data_i[r_lane*MINDATA_W +: MINDATA_W];
        assign busy_o           = 1'b0;
        assign r_valid_o        = r_rvalid;

    end else begin : g_same
        logic r_rvalid;
        logic w_unused;

        assign w_unused = flush_i;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_rvalid <= 1'b0;
            end else if (cke_i) begin
                r_rvalid <= r_en_i;
            end
        end

        assign ext_mem_w_en_o   = {R{w_en_i & cke_i}};
        assign ext_mem_w_addr_o = w_addr_i;
        assign ext_mem_w_data_o = w_data_i;
        assign ext_mem_r_en_o   = {R{r_en_i & cke_i}};
        assign ext_mem_r_addr_o = r_addr_i;
        assign r_data_o         = ext_mem_r_data_i;
        assign busy_o           = 1'b0;
        assign r_valid_o        = r_rvalid;
    end

endmodule
`default_nettype wire
